// File: rtl/if_id_pipe_ctrl.sv
// ============================================================================
// Module  : if_id_pipe_ctrl
// Brief   : IF/ID and ID/EX pipeline registers with stall/flush/bubble control,
//           saturating event counters and a sticky consecutive-stall watchdog.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_pipe_ctrl #(
  parameter logic [31:0] NOP_INSTR   = 32'h00000000,
  parameter int          STALL_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IF_PC4,
  input  logic [31:0] IF_Instr,
  input  logic        IF_ID_Write,
  input  logic        ID_EX_Mux,
  input  logic        Flush,
  input  logic [9:0]  ID_Ctrl,
  input  logic [4:0]  ID_RS,
  input  logic [4:0]  ID_RT,
  input  logic [4:0]  ID_RD,
  output logic [31:0] ID_PC4,
  output logic [31:0] ID_Instr,
  output logic        ID_Valid,
  output logic [9:0]  EX_Ctrl,
  output logic [4:0]  EX_RS,
  output logic [4:0]  EX_RT,
  output logic [4:0]  EX_RD,
  output logic        EX_Valid,
  output logic [1:0]  pipe_state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        stall_err
);

  localparam int CONSEC_W = ($clog2(STALL_LIMIT + 1) < 4) ? 4 : $clog2(STALL_LIMIT + 1);
  localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(STALL_LIMIT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } pipe_state_e;

  logic [31:0]         id_pc4_q,    id_pc4_d;
  logic [31:0]         id_instr_q,  id_instr_d;
  logic                id_valid_q,  id_valid_d;
  logic [9:0]          ex_ctrl_q,   ex_ctrl_d;
  logic [4:0]          ex_rs_q,     ex_rs_d;
  logic [4:0]          ex_rt_q,     ex_rt_d;
  logic [4:0]          ex_rd_q,     ex_rd_d;
  logic                ex_valid_q,  ex_valid_d;
  pipe_state_e         state_q,     state_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;
  logic [15:0]         flush_cnt_q, flush_cnt_d;
  logic [CONSEC_W-1:0] consec_q,    consec_d;
  logic                stall_err_q, stall_err_d;
  logic                stall_cycle;

  always_comb begin
    id_pc4_d    = id_pc4_q;
    id_instr_d  = id_instr_q;
    id_valid_d  = id_valid_q;
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    consec_d    = '0;
    stall_err_d = stall_err_q;
    stall_cycle = IF_ID_Write && !Flush;

    // ID/EX sees only the instruction currently in ID; Flush does not reach it.
    if (ID_EX_Mux || !id_valid_q) begin
      ex_ctrl_d  = '0;
      ex_rs_d    = '0;
      ex_rt_d    = '0;
      ex_rd_d    = '0;
      ex_valid_d = 1'b0;
    end else begin
      ex_ctrl_d  = ID_Ctrl;
      ex_rs_d    = ID_RS;
      ex_rt_d    = ID_RT;
      ex_rd_d    = ID_RD;
      ex_valid_d = 1'b1;
    end

    if (Flush) begin
      id_pc4_d   = '0;
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
      state_d    = ST_FLUSH;
      if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end else if (IF_ID_Write) begin
      state_d = ST_STALL;
      if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      id_pc4_d   = IF_PC4;
      id_instr_d = IF_Instr;
      id_valid_d = 1'b1;
      state_d    = ST_RUN;
    end

    if (stall_cycle) begin
      consec_d = (consec_q == CONSEC_MAX) ? consec_q : consec_q + 1'b1;
      if (consec_d == CONSEC_MAX) stall_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_pc4_q    <= '0;
      id_instr_q  <= NOP_INSTR;
      id_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_rd_q     <= '0;
      ex_valid_q  <= 1'b0;
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      consec_q    <= '0;
      stall_err_q <= 1'b0;
    end else begin
      id_pc4_q    <= id_pc4_d;
      id_instr_q  <= id_instr_d;
      id_valid_q  <= id_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_rd_q     <= ex_rd_d;
      ex_valid_q  <= ex_valid_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      consec_q    <= consec_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign ID_PC4     = id_pc4_q;
  assign ID_Instr   = id_instr_q;
  assign ID_Valid   = id_valid_q;
  assign EX_Ctrl    = ex_ctrl_q;
  assign EX_RS      = ex_rs_q;
  assign EX_RT      = ex_rt_q;
  assign EX_RD      = ex_rd_q;
  assign EX_Valid   = ex_valid_q;
  assign pipe_state = state_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign stall_err  = stall_err_q;

endmodule

`default_nettype wire

// File: tb/tb_if_id_pipe_ctrl.sv
// ============================================================================
// Module  : tb_if_id_pipe_ctrl
// Brief   : Scoreboard bench for if_id_pipe_ctrl against a cycle model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_pipe_ctrl;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int          LIM = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IF_PC4, IF_Instr;
  logic        IF_ID_Write, ID_EX_Mux, Flush;
  logic [9:0]  ID_Ctrl;
  logic [4:0]  ID_RS, ID_RT, ID_RD;
  logic [31:0] ID_PC4, ID_Instr;
  logic        ID_Valid;
  logic [9:0]  EX_Ctrl;
  logic [4:0]  EX_RS, EX_RT, EX_RD;
  logic        EX_Valid;
  logic [1:0]  pipe_state;
  logic [15:0] stall_cnt, flush_cnt;
  logic        stall_err;

  if_id_pipe_ctrl #(.NOP_INSTR(NOP), .STALL_LIMIT(LIM)) u_dut (
    .clk(clk), .reset(reset),
    .IF_PC4(IF_PC4), .IF_Instr(IF_Instr),
    .IF_ID_Write(IF_ID_Write), .ID_EX_Mux(ID_EX_Mux), .Flush(Flush),
    .ID_Ctrl(ID_Ctrl), .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_RD(ID_RD),
    .ID_PC4(ID_PC4), .ID_Instr(ID_Instr), .ID_Valid(ID_Valid),
    .EX_Ctrl(EX_Ctrl), .EX_RS(EX_RS), .EX_RT(EX_RT), .EX_RD(EX_RD),
    .EX_Valid(EX_Valid), .pipe_state(pipe_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc4, instr;
    logic        vld;
    logic [9:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic        ev;
    logic [1:0]  st;
    logic [15:0] sc, fc;
    logic        err;
  } exp_t;

  exp_t q_exp[$];
  exp_t m;
  int   m_consec;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Advance the reference model by one rising edge using the current inputs.
  task automatic model_edge();
    if (reset) begin
      m = '{pc4: 32'd0, instr: NOP, vld: 1'b0, ctrl: 10'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0,
            ev: 1'b0, st: 2'd0, sc: 16'd0, fc: 16'd0, err: 1'b0};
      m_consec = 0;
    end else begin
      if (ID_EX_Mux || !m.vld) begin
        m.ctrl = 0; m.rs = 0; m.rt = 0; m.rd = 0; m.ev = 0;
      end else begin
        m.ctrl = ID_Ctrl; m.rs = ID_RS; m.rt = ID_RT; m.rd = ID_RD; m.ev = 1;
      end
      if (Flush) begin
        m.pc4 = 0; m.instr = NOP; m.vld = 0; m.st = 2;
        if (m.fc != 16'hFFFF) m.fc++;
        m_consec = 0;
      end else if (IF_ID_Write) begin
        m.st = 1;
        if (m.sc != 16'hFFFF) m.sc++;
        if (m_consec < LIM) m_consec++;
        if (m_consec == LIM) m.err = 1;
      end else begin
        m.pc4 = IF_PC4; m.instr = IF_Instr; m.vld = 1; m.st = 0;
        m_consec = 0;
      end
    end
  endtask

  task automatic step(input bit chk);
    exp_t e;
    model_edge();
    q_exp.push_back(m);
    @(posedge clk);
    #1;
    e = q_exp.pop_front();
    if (chk) begin
      check("id_pc4",     ID_PC4,     e.pc4);
      check("id_instr",   ID_Instr,   e.instr);
      check("id_valid",   ID_Valid,   e.vld);
      check("ex_ctrl",    EX_Ctrl,    e.ctrl);
      check("ex_rs",      EX_RS,      e.rs);
      check("ex_rt",      EX_RT,      e.rt);
      check("ex_rd",      EX_RD,      e.rd);
      check("ex_valid",   EX_Valid,   e.ev);
      check("pipe_state", pipe_state, e.st);
      check("stall_cnt",  stall_cnt,  e.sc);
      check("flush_cnt",  flush_cnt,  e.fc);
      check("stall_err",  stall_err,  e.err);
    end
  endtask

  task automatic drive(input logic rst, input logic flush, input logic wr, input logic mux,
                       input logic [31:0] pc4, input logic [31:0] instr);
    reset = rst; Flush = flush; IF_ID_Write = wr; ID_EX_Mux = mux;
    IF_PC4 = pc4; IF_Instr = instr;
    ID_Ctrl = 10'($urandom); ID_RS = 5'($urandom); ID_RT = 5'($urandom); ID_RD = 5'($urandom);
  endtask

  initial begin
    m = '{pc4: 32'd0, instr: NOP, vld: 1'b0, ctrl: 10'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0,
          ev: 1'b0, st: 2'd0, sc: 16'd0, fc: 16'd0, err: 1'b0};
    m_consec = 0;
    drive(1, 0, 0, 0, 0, 0);
    step(1);
    step(1);

    // Free run
    drive(0, 0, 0, 0, 32'd4,  32'hAAAA_0001); step(1);
    check("run_a", ID_Instr, 32'hAAAA_0001);
    drive(0, 0, 0, 0, 32'd8,  32'hBBBB_0002); step(1);
    check("run_ev", EX_Valid, 1'b1);
    drive(0, 0, 0, 0, 32'd12, 32'hCCCC_0003); step(1);
    drive(0, 0, 0, 0, 32'd16, 32'hDDDD_0004); step(1);

    // Load-use: hold IF/ID and bubble ID/EX in one edge
    drive(0, 0, 1, 1, 32'd20, 32'hEEEE_0005); step(1);
    check("lu_hold", ID_Instr, 32'hDDDD_0004);
    check("lu_ev",   EX_Valid, 1'b0);
    check("lu_st",   pipe_state, 2'd1);
    check("lu_sc",   stall_cnt, 16'd1);

    // Flush wins over stall
    drive(0, 1, 1, 0, 32'd24, 32'hFFFF_0006); step(1);
    check("fl_instr", ID_Instr, NOP);
    check("fl_st",    pipe_state, 2'd2);
    check("fl_fc",    flush_cnt, 16'd1);
    check("fl_sc",    stall_cnt, 16'd1);
    drive(0, 0, 0, 0, 32'd28, 32'h1111_0007); step(1);
    check("fl_ev", EX_Valid, 1'b0);
    drive(0, 0, 0, 0, 32'd32, 32'h2222_0008); step(1);

    // Watchdog: 14 stalls then run does not trip
    drive(1, 0, 0, 0, 0, 0); step(1);
    for (int i = 0; i < LIM - 1; i++) begin drive(0, 0, 1, 0, 32'd36, 32'h3); step(1); end
    drive(0, 0, 0, 0, 32'd40, 32'h4); step(1);
    check("wd_14", stall_err, 1'b0);
    for (int i = 0; i < LIM; i++) begin
      drive(0, 0, 1, 0, 32'd44, 32'h5); step(1);
      if (i == LIM - 2) check("wd_pre", stall_err, 1'b0);
    end
    check("wd_15", stall_err, 1'b1);
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 32'd48 + 32'(4*i), 32'h6); step(1); end
    check("wd_sticky", stall_err, 1'b1);

    // Reset mid-stall
    drive(1, 0, 0, 0, 0, 0); step(1);
    drive(0, 0, 0, 0, 32'd100, 32'h7777_0001); step(1);
    for (int i = 0; i < 5; i++) begin drive(0, 0, 1, 1, 32'd104, 32'h8); step(1); end
    check("rs_sc5", stall_cnt, 16'd5);
    drive(1, 1, 1, 1, 32'd108, 32'h9); step(1);
    check("rs_sc0", stall_cnt, 16'd0);
    drive(0, 0, 0, 0, 32'd112, 32'h9999_0002); step(1);
    check("rs_load", ID_Instr, 32'h9999_0002);
    check("rs_vld",  ID_Valid, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            $urandom, $urandom);
      step(1);
    end

    // Saturation of stall_cnt
    drive(1, 0, 0, 0, 0, 0); step(1);
    for (int i = 0; i < 65537; i++) begin
      drive(0, 0, 1, 0, 32'd0, 32'h0);
      step(i >= 65533);
    end
    check("sat", stall_cnt, 16'hFFFF);
    drive(0, 0, 0, 0, 32'd4, 32'h1); step(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
